sal_sched_arbiter: RTL and testbench
====================================

# sal_sched_arbiter

Parametrised multi-bank command arbiter between the per-bank controllers and the DFI command path. Accepts one scheduler request bundle per bank (act/rd/wr/pre/ref with ba/ra/ca/id/len), grants at most one bank per cycle by class priority plus round-robin fairness, and enforces the inter-bank timing constraints tRRD, tCCD, tWTR and tRTW. The granted command is registered and presented on a single command output.

## Interface
Parameters:
- NUM_BANKS, 4, number of bank request bundles (power of two, 2..16)
- BA_WIDTH, $clog2(NUM_BANKS), bank address width
- RA_WIDTH, 16 / CA_WIDTH, 10 / ID_WIDTH, 4 / LEN_WIDTH, 4, request field widths
- T_RRD_WIDTH, 3 / T_CCD_WIDTH, 3 / T_WTR_WIDTH, 4 / T_RTW_WIDTH, 4, timing counter widths

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- act_req, rd_req, wr_req, pre_req, ref_req  in  NUM_BANKS each  per-bank request bits
- ra  in  NUM_BANKS*RA_WIDTH  per-bank row address, bank i at [i*RA_WIDTH +: RA_WIDTH]
- ca, id, len  in  NUM_BANKS*{CA,ID,LEN}_WIDTH  per-bank fields, same packing
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  NUM_BANKS each  one-hot-or-zero grant, combinational
- t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  in  T_*_WIDTH  timing minus one, quasi-static
- cmd_valid  out  1  registered command strobe
- cmd_type  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
- cmd_ba  out  BA_WIDTH  granted bank
- cmd_ra, cmd_ca, cmd_id, cmd_len  out  field widths  granted bank's fields

## Operation
- Bank's effective request = highest of its asserted bits in order REF > PRE > ACT > RD > WR; other bits ignored that cycle.
- Eligibility: ACT blocked while rrd_cnt != 0; RD blocked while ccd_cnt != 0 or wtr_cnt != 0; WR blocked while ccd_cnt != 0 or rtw_cnt != 0; PRE/REF never blocked.
- Class priority among eligible requests: REF > PRE > ACT > column (RD and WR one class). A blocked class never stalls a lower eligible class.
- Within the winning class, round-robin: search banks rr_ptr, rr_ptr+1, ... modulo NUM_BANKS; first hit wins.
- Exactly one grant bit asserted per cycle when any eligible request exists, else all zero. Grant is same-cycle with request; bank deasserts req the cycle after grant.
- On grant: rr_ptr <= (granted bank + 1) mod NUM_BANKS (wrap at NUM_BANKS-1 -> 0). No grant: rr_ptr holds.
- Counters load on grant edge, otherwise decrement saturating at 0: ACT loads rrd_cnt <= t_rrd_m1; RD loads ccd_cnt <= t_ccd_m1, rtw_cnt <= t_rtw_m1; WR loads ccd_cnt <= t_ccd_m1, wtr_cnt <= t_wtr_m1. Load overrides decrement. Loading 0 imposes no block.
- Refresh-readiness of all banks is upstream responsibility; no check here.

## Timing
- Reset: all grants 0, cmd_valid 0, cmd_type 0, all cmd_* fields 0, all counters 0, rr_ptr 0. Reset mid-operation aborts any pending counter immediately; first cycle after release grants freely.
- Command latency: grant in cycle T -> cmd_valid=1 with matching fields in cycle T+1; cmd_valid=0, cmd_type=0 in cycles following no-grant cycles (fields hold last value).
- Spacing: two same-constrained commands granted at T and T+t_x_m1+1 minimum (e.g. t_rrd_m1=3 -> ACTs at T, T+4).
- Timing inputs sampled only at load; change while counting has no effect on the running count.

## Test plan
- Reset: rst_n low with all req bits high -> all gnt 0, cmd_valid 0; release -> bank 0 REF granted first cycle, cmd_type=5, cmd_ba=0 next cycle.
- Round-robin: act_req=4'b1111 held, t_rrd_m1=0 -> grants banks 0,1,2,3,0 on consecutive cycles, rr_ptr wraps 3->0.
- tRRD: t_rrd_m1=3, banks 0 and 2 request ACT at T -> bank 0 at T, bank 2 at T+4, no ACT grant T+1..T+3.
- Class bypass: rrd blocked, bank 1 ACT and bank 3 RD pending -> bank 3 rd_gnt same cycle; PRE on bank 2 added -> pre_gnt to bank 2 wins over RD.
- RD->WR / WR->RD: t_rtw_m1=5, t_ccd_m1=1: RD at T, WR pending -> WR at T+6; t_wtr_m1=7: WR at T, RD -> at T+8.
- Multi-bit bank: bank 0 asserts ACT+RD -> act_gnt[0] only; cmd_ra equals bank 0's ra field.

Source files
------------

// File: rtl/sal_sched_arbiter.sv
// sal_sched_arbiter: multi-bank command arbiter with class priority, round-robin
// fairness and tRRD/tCCD/tWTR/tRTW spacing, feeding one registered command output.
module sal_sched_arbiter #(
    parameter int NUM_BANKS   = 4,
    parameter int BA_WIDTH    = $clog2(NUM_BANKS),
    parameter int RA_WIDTH    = 16,
    parameter int CA_WIDTH    = 10,
    parameter int ID_WIDTH    = 4,
    parameter int LEN_WIDTH   = 4,
    parameter int T_RRD_WIDTH = 3,
    parameter int T_CCD_WIDTH = 3,
    parameter int T_WTR_WIDTH = 4,
    parameter int T_RTW_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BANKS-1:0]           act_req,
    input  logic [NUM_BANKS-1:0]           rd_req,
    input  logic [NUM_BANKS-1:0]           wr_req,
    input  logic [NUM_BANKS-1:0]           pre_req,
    input  logic [NUM_BANKS-1:0]           ref_req,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  id,
    input  logic [NUM_BANKS*LEN_WIDTH-1:0] len,
    output logic [NUM_BANKS-1:0]           act_gnt,
    output logic [NUM_BANKS-1:0]           rd_gnt,
    output logic [NUM_BANKS-1:0]           wr_gnt,
    output logic [NUM_BANKS-1:0]           pre_gnt,
    output logic [NUM_BANKS-1:0]           ref_gnt,
    input  logic [T_RRD_WIDTH-1:0]         t_rrd_m1,
    input  logic [T_CCD_WIDTH-1:0]         t_ccd_m1,
    input  logic [T_WTR_WIDTH-1:0]         t_wtr_m1,
    input  logic [T_RTW_WIDTH-1:0]         t_rtw_m1,
    output logic                           cmd_valid,
    output logic [2:0]                     cmd_type,
    output logic [BA_WIDTH-1:0]            cmd_ba,
    output logic [RA_WIDTH-1:0]            cmd_ra,
    output logic [CA_WIDTH-1:0]            cmd_ca,
    output logic [ID_WIDTH-1:0]            cmd_id,
    output logic [LEN_WIDTH-1:0]           cmd_len
);
    logic [BA_WIDTH-1:0]    rr_ptr, gnt_idx, idx;
    logic [T_RRD_WIDTH-1:0] rrd_cnt;
    logic [T_CCD_WIDTH-1:0] ccd_cnt;
    logic [T_WTR_WIDTH-1:0] wtr_cnt;
    logic [T_RTW_WIDTH-1:0] rtw_cnt;
    logic [NUM_BANKS-1:0]   ref_v, pre_v, act_v, rd_v, wr_v, col_v, cls, gnt;
    logic                   gnt_any;
    logic [2:0]             gnt_type;

    always_comb begin
        ref_v   = ref_req;
        pre_v   = pre_req & ~ref_req;
        act_v   = act_req & ~ref_req & ~pre_req;
        rd_v    = rd_req & ~ref_req & ~pre_req & ~act_req;
        wr_v    = wr_req & ~ref_req & ~pre_req & ~act_req & ~rd_req;
        col_v   = (ccd_cnt == '0 && wtr_cnt == '0 ? rd_v : '0) |
                  (ccd_cnt == '0 && rtw_cnt == '0 ? wr_v : '0);
        // a blocked ACT class falls through to the column class
        cls     = !rst_n ? '0 : |ref_v ? ref_v : |pre_v ? pre_v :
                  (rrd_cnt == '0 && |act_v) ? act_v : col_v;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx = rr_ptr + BA_WIDTH'(k);
            if (!gnt_any && cls[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
    end

    assign ref_gnt  = gnt & ref_v;
    assign pre_gnt  = gnt & pre_v;
    assign act_gnt  = gnt & act_v;
    assign rd_gnt   = gnt & rd_v;
    assign wr_gnt   = gnt & wr_v;
    assign gnt_type = |ref_gnt ? 3'd5 : |pre_gnt ? 3'd4 : |act_gnt ? 3'd1 :
                      |rd_gnt ? 3'd2 : |wr_gnt ? 3'd3 : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rrd_cnt   <= '0;
            ccd_cnt   <= '0;
            wtr_cnt   <= '0;
            rtw_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd_type  <= 3'd0;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            rr_ptr    <= gnt_any ? gnt_idx + BA_WIDTH'(1) : rr_ptr;
            rrd_cnt   <= |act_gnt ? t_rrd_m1 : rrd_cnt == '0 ? '0 : rrd_cnt - T_RRD_WIDTH'(1);
            ccd_cnt   <= (|rd_gnt || |wr_gnt) ? t_ccd_m1 : ccd_cnt == '0 ? '0 : ccd_cnt - T_CCD_WIDTH'(1);
            rtw_cnt   <= |rd_gnt ? t_rtw_m1 : rtw_cnt == '0 ? '0 : rtw_cnt - T_RTW_WIDTH'(1);
            wtr_cnt   <= |wr_gnt ? t_wtr_m1 : wtr_cnt == '0 ? '0 : wtr_cnt - T_WTR_WIDTH'(1);
            cmd_valid <= gnt_any;
            cmd_type  <= gnt_type;
            if (gnt_any) begin
                cmd_ba  <= gnt_idx;
                cmd_ra  <= ra[int'(gnt_idx)*RA_WIDTH +: RA_WIDTH];
                cmd_ca  <= ca[int'(gnt_idx)*CA_WIDTH +: CA_WIDTH];
                cmd_id  <= id[int'(gnt_idx)*ID_WIDTH +: ID_WIDTH];
                cmd_len <= len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_sal_sched_arbiter.sv
// tb_sal_sched_arbiter: directed vector table plus timing/reset sequences for a 4-bank arbiter.
module tb_sal_sched_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  act_req, rd_req, wr_req, pre_req, ref_req;
    logic [63:0] ra;
    logic [39:0] ca;
    logic [15:0] id, len;
    logic [3:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [2:0]  t_rrd_m1 = '0, t_ccd_m1 = '0;
    logic [3:0]  t_wtr_m1 = '0, t_rtw_m1 = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_ra;
    logic [9:0]  cmd_ca;
    logic [3:0]  cmd_id, cmd_len;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0] act, rd, wr, pre, rf, e_gnt;
        logic [2:0] e_type;
    } vec_t;

    sal_sched_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra(ra), .ca(ca), .id(id), .len(len),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
        .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] a, r, w, p, f, g, logic [2:0] t);
        vec_t v;
        v.act = a; v.rd = r; v.wr = w; v.pre = p; v.rf = f; v.e_gnt = g; v.e_type = t;
        return v;
    endfunction

    function automatic int oh2idx(logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic cyc(input vec_t v, input string n);
        int b;
        @(negedge clk);
        act_req = v.act; rd_req = v.rd; wr_req = v.wr; pre_req = v.pre; ref_req = v.rf;
        #1;
        chk({n, "/act_gnt"}, 32'(act_gnt), 32'(v.e_type == 3'd1 ? v.e_gnt : 4'b0));
        chk({n, "/rd_gnt"},  32'(rd_gnt),  32'(v.e_type == 3'd2 ? v.e_gnt : 4'b0));
        chk({n, "/wr_gnt"},  32'(wr_gnt),  32'(v.e_type == 3'd3 ? v.e_gnt : 4'b0));
        chk({n, "/pre_gnt"}, 32'(pre_gnt), 32'(v.e_type == 3'd4 ? v.e_gnt : 4'b0));
        chk({n, "/ref_gnt"}, 32'(ref_gnt), 32'(v.e_type == 3'd5 ? v.e_gnt : 4'b0));
        @(posedge clk);
        #1;
        chk({n, "/cmd_valid"}, 32'(cmd_valid), 32'(v.e_type != 3'd0));
        chk({n, "/cmd_type"},  32'(cmd_type),  32'(v.e_type));
        if (v.e_type != 3'd0) begin
            b = oh2idx(v.e_gnt);
            chk({n, "/cmd_ba"},  32'(cmd_ba),  32'(b));
            chk({n, "/cmd_ra"},  32'(cmd_ra),  32'(16'hA000 + 16'(b)));
            chk({n, "/cmd_ca"},  32'(cmd_ca),  32'(10'h100 + 10'(b)));
            chk({n, "/cmd_id"},  32'(cmd_id),  32'(b + 3));
            chk({n, "/cmd_len"}, 32'(cmd_len), 32'(15 - b));
        end
    endtask

    initial begin
        vec_t tbl[$];
        for (int i = 0; i < 4; i++) begin
            ra[i*16 +: 16] = 16'hA000 + 16'(i);
            ca[i*10 +: 10] = 10'h100 + 10'(i);
            id[i*4 +: 4]   = 4'(i + 3);
            len[i*4 +: 4]  = 4'(15 - i);
        end
        act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/gnt_any", 32'(act_gnt | rd_gnt | wr_gnt | pre_gnt | ref_gnt), 32'h0);
        chk("rst/cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst/cmd_type", 32'(cmd_type), 32'h0);
        chk("rst/cmd_ra", 32'(cmd_ra), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(mk('1, '1, '1, '1, '1, 4'b0001, 3'd5), "rst_release");

        // all timings zero; rr_ptr starts at 1 here
        tbl.push_back(mk(4'b1111, 0, 0, 0, 0, 4'b0010, 3'd1));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 0, 4'b0100, 3'd1));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 0, 4'b1000, 3'd1));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 0, 4'b0001, 3'd1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 3'd0));
        tbl.push_back(mk(0, 4'b0101, 0, 0, 0, 4'b0100, 3'd2));
        tbl.push_back(mk(0, 0, 4'b1001, 0, 0, 4'b1000, 3'd3));
        tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 0, 4'b0001, 3'd1));
        tbl.push_back(mk(4'b1111, 4'b1111, 0, 4'b0100, 0, 4'b0100, 3'd4));
        tbl.push_back(mk(4'b1111, 0, 0, 4'b1000, 4'b0010, 4'b0010, 3'd5));
        tbl.push_back(mk(0, 4'b0001, 4'b1000, 0, 4'b1000, 4'b1000, 3'd5));
        tbl.push_back(mk(0, 0, 4'b0110, 0, 0, 4'b0010, 3'd3));
        tbl.push_back(mk(0, 4'b0010, 4'b0100, 0, 0, 4'b0100, 3'd3));
        tbl.push_back(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 3'd2));
        foreach (tbl[i]) cyc(tbl[i], $sformatf("tbl%0d", i));

        // tRRD spacing: rr_ptr 2 -> steer to 0 with a PRE on bank 3
        t_rrd_m1 = 3'd3;
        cyc(mk(0, 0, 0, 4'b1000, 0, 4'b1000, 3'd4), "rrd_align");
        cyc(mk(4'b0101, 0, 0, 0, 0, 4'b0001, 3'd1), "rrd_T");
        for (int i = 1; i <= 3; i++) cyc(mk(4'b0100, 0, 0, 0, 0, 4'b0000, 3'd0), $sformatf("rrd_T+%0d", i));
        cyc(mk(4'b0100, 0, 0, 0, 0, 4'b0100, 3'd1), "rrd_T+4");

        // ACT blocked: column and PRE classes still proceed
        cyc(mk(4'b0010, 4'b1000, 0, 0, 0, 4'b1000, 3'd2), "bypass_rd");
        cyc(mk(4'b0010, 4'b1000, 0, 4'b0100, 0, 4'b0100, 3'd4), "bypass_pre");
        cyc(mk(4'b0010, 0, 0, 0, 0, 4'b0000, 3'd0), "bypass_wait");
        cyc(mk(4'b0010, 0, 0, 0, 0, 4'b0010, 3'd1), "bypass_act");
        t_rrd_m1 = 3'd0;

        // RD->WR then WR->RD turnarounds
        t_rtw_m1 = 4'd5; t_ccd_m1 = 3'd1; t_wtr_m1 = 4'd7;
        cyc(mk(0, 4'b0100, 0, 0, 0, 4'b0100, 3'd2), "rtw_T");
        t_rtw_m1 = 4'd15;
        for (int i = 1; i <= 5; i++) cyc(mk(0, 0, 4'b0001, 0, 0, 4'b0000, 3'd0), $sformatf("rtw_T+%0d", i));
        cyc(mk(0, 0, 4'b0001, 0, 0, 4'b0001, 3'd3), "rtw_T+6");
        for (int i = 1; i <= 7; i++) cyc(mk(0, 4'b0010, 0, 0, 0, 4'b0000, 3'd0), $sformatf("wtr_T+%0d", i));
        cyc(mk(0, 4'b0010, 0, 0, 0, 4'b0010, 3'd2), "wtr_T+8");

        // reset mid-operation clears counters and rr_ptr
        t_rrd_m1 = 3'd7;
        cyc(mk(4'b0100, 0, 0, 0, 0, 4'b0100, 3'd1), "midrst_act");
        #2 rst_n = 1'b0;
        act_req = 4'b1111;
        #1;
        chk("midrst/act_gnt", 32'(act_gnt), 32'h0);
        chk("midrst/cmd_valid", 32'(cmd_valid), 32'h0);
        chk("midrst/cmd_type", 32'(cmd_type), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(mk(4'b1111, 0, 0, 0, 0, 4'b0001, 3'd1), "midrst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
